hms_time_counter: RTL and testbench



---
 rtl/hms_time_counter.sv | 122 ++++++++++++
 tb/tb_hms_time_counter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hms_time_counter.sv
// hms_time_counter: BCD hours/minutes/seconds time-of-day counter.
// Brings the divider's ~1 Hz sec_clk into the in_clk domain through a
// three-flop chain, counts its rising edges, and offers a halted set mode
// where button pulses advance individual fields.
module hms_time_counter #(
    parameter int unsigned HOUR_MAX = 23,
    parameter int unsigned MIN_MAX  = 59
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       sec_clk,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       inc,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse
);

    // Wrap limits converted once from decimal to packed BCD.
    localparam logic [7:0] HOUR_MAX_BCD = 8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));
    localparam logic [7:0] MIN_MAX_BCD  = 8'(((MIN_MAX / 10) << 4) | (MIN_MAX % 10));

    // Synchroniser chain; s3 only exists to detect the rising edge of s2.
    logic s1_q, s2_q, s3_q;
    logic tick;

    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hour_q, hour_d;
    logic       min_pulse_q, min_pulse_d;
    logic       hour_pulse_q, hour_pulse_d;
    logic       day_pulse_q, day_pulse_d;

    // Candidate increments for each field: {wrapped, next value}.
    logic [8:0] sec_nx, min_nx, hour_nx;

    // One-step BCD increment with wrap to 00 at maxv; bit 8 flags the wrap.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        logic [8:0] r;
        if (v == maxv) begin
            r = 9'h100;
        end else if (v[3:0] == 4'd9) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign tick = s2_q & ~s3_q;

    // Next-state: set mode swallows ticks; counting cascades seconds->minutes->hours in one edge.
    always_comb begin
        sec_nx       = bcd_inc(sec_q, MIN_MAX_BCD);
        min_nx       = bcd_inc(min_q, MIN_MAX_BCD);
        hour_nx      = bcd_inc(hour_q, HOUR_MAX_BCD);
        sec_d        = sec_q;
        min_d        = min_q;
        hour_d       = hour_q;
        min_pulse_d  = 1'b0;
        hour_pulse_d = 1'b0;
        day_pulse_d  = 1'b0;
        if (set_en) begin
            if (inc) begin
                case (set_sel)
                    2'b00:   sec_d  = 8'h00;
                    2'b01:   min_d  = min_nx[7:0];
                    2'b10:   hour_d = hour_nx[7:0];
                    default: ;
                endcase
            end
        end else if (tick) begin
            sec_d = sec_nx[7:0];
            if (sec_nx[8]) begin
                min_d       = min_nx[7:0];
                min_pulse_d = 1'b1;
                if (min_nx[8]) begin
                    hour_d       = hour_nx[7:0];
                    hour_pulse_d = 1'b1;
                    day_pulse_d  = hour_nx[8];
                end
            end
        end
    end

    // State registers and synchroniser; reset clears everything and masks a same-cycle tick.
    always_ff @(posedge in_clk) begin
        if (!rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            sec_q        <= 8'h00;
            min_q        <= 8'h00;
            hour_q       <= 8'h00;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            day_pulse_q  <= 1'b0;
        end else begin
            s1_q         <= sec_clk;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            min_pulse_q  <= min_pulse_d;
            hour_pulse_q <= hour_pulse_d;
            day_pulse_q  <= day_pulse_d;
        end
    end

    assign sec_bcd    = sec_q;
    assign min_bcd    = min_q;
    assign hour_bcd   = hour_q;
    assign min_pulse  = min_pulse_q;
    assign hour_pulse = hour_pulse_q;
    assign day_pulse  = day_pulse_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: a 24-hour and a 12-hour build share the same
// stimulus and are compared every cycle against a seconds-of-day model.
module tb_hms_time_counter;

    logic       in_clk;
    logic       rst;
    logic       sec_clk;
    logic       set_en;
    logic [1:0] set_sel;
    logic       inc;

    logic [7:0] a_sec, a_min, a_hour;
    logic       a_mp, a_hp, a_dp;
    logic [7:0] b_sec, b_min, b_hour;
    logic       b_mp, b_hp, b_dp;

    int n_tests = 0;
    int n_fail  = 0;
    bit mdl_en  = 0;

    hms_time_counter #(.HOUR_MAX(23), .MIN_MAX(59)) dut24 (
        .in_clk(in_clk), .rst(rst), .sec_clk(sec_clk), .set_en(set_en),
        .set_sel(set_sel), .inc(inc),
        .sec_bcd(a_sec), .min_bcd(a_min), .hour_bcd(a_hour),
        .min_pulse(a_mp), .hour_pulse(a_hp), .day_pulse(a_dp)
    );

    hms_time_counter #(.HOUR_MAX(11), .MIN_MAX(59)) dut12 (
        .in_clk(in_clk), .rst(rst), .sec_clk(sec_clk), .set_en(set_en),
        .set_sel(set_sel), .inc(inc),
        .sec_bcd(b_sec), .min_bcd(b_min), .hour_bcd(b_hour),
        .min_pulse(b_mp), .hour_pulse(b_hp), .day_pulse(b_dp)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    // ---------------- reference model: time as seconds since midnight ----------------
    int       t24, t12;
    bit       mp24, hp24, dp24, mp12, hp12, dp12;
    bit [2:0] hist;   // hist[k] = sec_clk sampled k+1 edges ago

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int set_op(input int t, input logic [1:0] sel, input int hmod);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        case (sel)
            2'd0:    s = 0;
            2'd1:    m = (m + 1) % 60;
            2'd2:    h = (h + 1) % hmod;
            default: ;
        endcase
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [26:0] view(input int t, input bit mp, input bit hp, input bit dp);
        return {to_bcd(t / 3600), to_bcd((t / 60) % 60), to_bcd(t % 60), mp, hp, dp};
    endfunction

    always @(posedge in_clk) begin
        if (!rst) begin
            t24 <= 0; t12 <= 0; hist <= 3'b000;
            {mp24, hp24, dp24, mp12, hp12, dp12} <= 6'b0;
        end else begin
            {mp24, hp24, dp24, mp12, hp12, dp12} <= 6'b0;
            if (set_en) begin
                if (inc) begin
                    t24 <= set_op(t24, set_sel, 24);
                    t12 <= set_op(t12, set_sel, 12);
                end
            end else if (hist[1] && !hist[2]) begin
                mp24 <= (t24 % 60 == 59);
                hp24 <= (t24 % 3600 == 3599);
                dp24 <= (t24 == 86399);
                t24  <= (t24 + 1) % 86400;
                mp12 <= (t12 % 60 == 59);
                hp12 <= (t12 % 3600 == 3599);
                dp12 <= (t12 == 43199);
                t12  <= (t12 + 1) % 43200;
            end
            hist <= {hist[1:0], sec_clk};
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on the falling edge.
    always @(negedge in_clk) begin
        if (mdl_en) begin
            check("model24", 32'({a_hour, a_min, a_sec, a_mp, a_hp, a_dp}), 32'(view(t24, mp24, hp24, dp24)));
            check("model12", 32'({b_hour, b_min, b_sec, b_mp, b_hp, b_dp}), 32'(view(t12, mp12, hp12, dp12)));
        end
    end

    task automatic clk(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic rise();
        sec_clk = 1'b1; clk(3);
        sec_clk = 1'b0; clk(3);
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       inc;
        logic [7:0] es, em, eh;
    } vec_t;

    vec_t tbl[7];
    bit   seen;

    initial begin
        tbl[0] = '{2'b01, 1'b1, 8'h10, 8'h01, 8'h00};
        tbl[1] = '{2'b01, 1'b0, 8'h10, 8'h01, 8'h00};
        tbl[2] = '{2'b10, 1'b1, 8'h10, 8'h01, 8'h01};
        tbl[3] = '{2'b11, 1'b1, 8'h10, 8'h01, 8'h01};
        tbl[4] = '{2'b00, 1'b1, 8'h00, 8'h01, 8'h01};
        tbl[5] = '{2'b01, 1'b1, 8'h00, 8'h02, 8'h01};
        tbl[6] = '{2'b10, 1'b1, 8'h00, 8'h02, 8'h02};

        rst = 1'b0; sec_clk = 1'b1; set_en = 1'b0; set_sel = 2'b00; inc = 1'b0;

        // Reset with sec_clk high, then release: exactly one tick.
        clk(1);
        mdl_en = 1;
        clk(2);
        check("rst_time24", 32'({a_hour, a_min, a_sec}), 32'h0);
        check("rst_puls24", 32'({a_mp, a_hp, a_dp}), 32'h0);
        check("rst_time12", 32'({b_hour, b_min, b_sec, b_mp, b_hp, b_dp}), 32'h0);
        rst = 1'b1;
        clk(2);
        check("rel_edge2", 32'(a_sec), 32'h00);
        clk(1);
        check("rel_edge3", 32'(a_sec), 32'h01);
        clk(4);
        check("rel_single", 32'(a_sec), 32'h01);

        // Latency and edge detect over 10 sec_clk periods.
        rst = 1'b0; sec_clk = 1'b0; clk(2);
        rst = 1'b1; clk(3);
        for (int i = 0; i < 10; i++) begin
            sec_clk = 1'b1; clk(2);
            check("lat_pre", 32'(a_sec), 32'(to_bcd(i)));
            clk(1);
            check("lat_post", 32'(a_sec), 32'(to_bcd(i + 1)));
            clk(2);
            sec_clk = 1'b0; clk(5);
            check("lat_fall", 32'(a_sec), 32'(to_bcd(i + 1)));
        end
        check("lat_final", 32'(a_sec), 32'h10);

        // Table-driven set-mode operations starting from 00:00:10.
        set_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_sel = tbl[i].sel; inc = tbl[i].inc;
            clk(1);
            check("tbl_time", 32'({a_hour, a_min, a_sec}), 32'({tbl[i].eh, tbl[i].em, tbl[i].es}));
            check("tbl_puls", 32'({a_mp, a_hp, a_dp}), 32'h0);
        end
        inc = 1'b0; set_en = 1'b0; clk(2);

        // Set-mode minute and hour wrap with sec_clk toggling throughout.
        rst = 1'b0; clk(1); rst = 1'b1;
        repeat (3) rise();
        set_en = 1'b1; set_sel = 2'b01; inc = 1'b1; seen = 0;
        for (int i = 0; i < 60; i++) begin
            sec_clk = i[1]; clk(1);
            seen |= a_mp | a_hp | a_dp;
            if (i == 58) check("set_min59", 32'(a_min), 32'h59);
        end
        check("set_min_wrap", 32'({a_hour, a_min, a_sec}), 32'h000003);
        set_sel = 2'b10;
        for (int i = 0; i < 24; i++) begin
            sec_clk = i[1]; clk(1);
            seen |= a_mp | a_hp | a_dp | b_mp | b_hp | b_dp;
            if (i == 22) begin
                check("set_hr23", 32'(a_hour), 32'h23);
                check("set_hr11", 32'(b_hour), 32'h11);
            end
        end
        check("set_hr_wrap", 32'({a_hour, b_hour, a_sec}), 32'h000003);
        check("set_no_pulse", 32'(seen), 32'h0);
        inc = 1'b0; sec_clk = 1'b0; clk(4);
        set_en = 1'b0; clk(4);
        check("set_exit", 32'(a_sec), 32'h03);

        // Minute carry: 00:00:59 -> 00:01:00.
        set_en = 1'b1; set_sel = 2'b00; inc = 1'b1; clk(1);
        inc = 1'b0; set_en = 1'b0; clk(1);
        repeat (59) rise();
        check("pre_carry", 32'({a_hour, a_min, a_sec}), 32'h000059);
        sec_clk = 1'b1; clk(3);
        check("carry_time", 32'({a_hour, a_min, a_sec}), 32'h000100);
        check("carry_puls", 32'({a_mp, a_hp, a_dp}), 32'b100);
        clk(1);
        check("carry_clr", 32'({a_mp, a_hp, a_dp}), 32'b000);
        sec_clk = 1'b0; clk(2);

        // Full-day wrap on both builds: preset 23:59:59 / 11:59:59.
        set_en = 1'b1; inc = 1'b1;
        set_sel = 2'b01; clk(58);
        set_sel = 2'b10; clk(23);
        inc = 1'b0; set_en = 1'b0; clk(2);
        repeat (59) rise();
        check("pre_day24", 32'({a_hour, a_min, a_sec}), 32'h235959);
        check("pre_day12", 32'({b_hour, b_min, b_sec}), 32'h115959);
        sec_clk = 1'b1; clk(3);
        check("day24_time", 32'({a_hour, a_min, a_sec}), 32'h000000);
        check("day24_puls", 32'({a_mp, a_hp, a_dp}), 32'b111);
        check("day12_time", 32'({b_hour, b_min, b_sec}), 32'h000000);
        check("day12_puls", 32'({b_mp, b_hp, b_dp}), 32'b111);
        clk(1);
        check("day_clr", 32'({a_mp, a_hp, a_dp, b_mp, b_hp, b_dp}), 32'h0);
        sec_clk = 1'b0; clk(3);

        // Set/tick collision: set_en rises in the very cycle the tick is live.
        sec_clk = 1'b1; clk(2);
        set_en = 1'b1; clk(1);
        check("coll_lost", 32'(a_sec), 32'h00);
        set_en = 1'b0; clk(3);
        check("coll_nostale", 32'(a_sec), 32'h00);
        sec_clk = 1'b0; clk(3);
        rise();
        check("coll_resume", 32'(a_sec), 32'h01);

        // Randomised traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) sec_clk = ~sec_clk;
            if ($urandom_range(0, 24) == 0) set_en = ~set_en;
            set_sel = 2'($urandom_range(0, 3));
            inc     = 1'($urandom_range(0, 1));
            clk(1);
        end

        rst = 1'b1; set_en = 1'b0; inc = 1'b0; clk(2);
        mdl_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
